prm_scan_ctrl: RTL and testbench

Sweep sequencer that drives the edge-check result bank from the reading side. For each 14-bit test index in a programmed range it:
- presents the index as `slv_reg0`, clears the accumulator and waits for edges to settle;
- walks `sel1`/`sel2` through all 128 32-bit result words;
- streams every word out on a valid/ready interface tagged with index and word number.

It sits between the host register file and the 4096-bit edge accumulator.

---
 rtl/prm_scan_pkg.sv | 43 ++++
 rtl/prm_scan_rd_pipe.sv | 38 +++
 rtl/prm_scan_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_prm_scan_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_scan_pkg.sv
// prm_scan_pkg: shared types and constants for the prm_scan sweep sequencer.
// The state enum, index/word geometry and the word -> (sel1, sel2) mapping
// live here so the controller and any bench agree on them.
package prm_scan_pkg;

    localparam int IDX_W  = 14;
    localparam int WORDS  = 128;
    localparam int WORD_W = 7;
    localparam int DATA_W = 32;

    // Test index field layout as seen by the checker: {x, y, z}
    localparam int X_W = 4;
    localparam int Y_W = 5;
    localparam int Z_W = 5;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [Z_W-1:0] z;
    } idx_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SETTLE  = 3'd2,
        SEL     = 3'd3,
        WAIT_RD = 3'd4,
        EMIT    = 3'd5,
        NEXT    = 3'd6
    } state_t;

    // Upper three word bits pick the result bank
    function automatic logic [2:0] bank_of(input logic [WORD_W-1:0] w);
        return w[6:4];
    endfunction

    // Lower four word bits pick the word inside the bank; the top nibble of
    // sel2 is unused by the accumulator and is held at zero
    function automatic logic [7:0] word_sel_of(input logic [WORD_W-1:0] w);
        return {4'b0000, w[3:0]};
    endfunction

endpackage

// File: rtl/prm_scan_rd_pipe.sv
// prm_scan_rd_pipe: LAT-deep valid delay line. A one-cycle req marks the
// cycle in which sel1/sel2 first show a new word; stb fires LAT cycles later,
// when result_imp for that word is valid. LAT = 0 is a straight wire, for a
// bank whose read path is purely combinational.
module prm_scan_rd_pipe #(
    parameter int LAT = 1
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic flush,
    input  logic req,
    output logic stb
);

    generate
        if (LAT == 0) begin : g_comb
            assign stb = req;
        end else begin : g_delay
            logic [LAT-1:0] sh_reg;

            // Shift the request through LAT stages; flush drops anything in
            // flight so an aborted read can never strobe a later sweep
            always_ff @(posedge CLK) begin
                if (!RST_n || flush) begin
                    sh_reg <= '0;
                end else begin
                    sh_reg[0] <= req;
                    for (int i = 1; i < LAT; i++) begin
                        sh_reg[i] <= sh_reg[i-1];
                    end
                end
            end

            assign stb = sh_reg[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/prm_scan_ctrl.sv
// prm_scan_ctrl: sweep sequencer for the edge-check result bank.
// For each index in [idx_first .. idx_last] (wrapping through 16383 -> 0) it
// clears the accumulator, waits SETTLE_CYC cycles, reads all 128 result words
// through sel1/sel2 and streams them on a valid/ready port tagged with index
// and word number. Every output is a register.
// Optional build macro: PRM_SCAN_SKIP_ZERO_EN -- when defined, captured words
// equal to zero are dropped from the stream (word 127 is always sent so the
// m_last beat still appears).
module prm_scan_ctrl
    import prm_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int READ_LAT   = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  idx_first,
    input  logic [IDX_W-1:0]  idx_last,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  slv_reg0,
    output logic              chk_clr_n,
    output logic [2:0]        sel1,
    output logic [7:0]        sel2,
    input  logic [DATA_W-1:0] result_imp,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_idx,
    output logic [WORD_W-1:0] m_word,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

`ifdef PRM_SCAN_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(WORDS - 1);
    localparam logic [7:0]        SETTLE_END = 8'(SETTLE_CYC - 1);

    // Sequencer state
    state_t              state_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    last_reg;
    logic [WORD_W-1:0]   w_reg;
    logic [7:0]          settle_cnt_reg;

    // Output registers
    logic                busy_reg;
    logic                done_reg;
    logic [IDX_W-1:0]    slv_reg0_reg;
    logic                chk_clr_n_reg;
    logic [2:0]          sel1_reg;
    logic [7:0]          sel2_reg;
    logic [DATA_W-1:0]   m_data_reg;
    logic [IDX_W-1:0]    m_idx_reg;
    logic [WORD_W-1:0]   m_word_reg;
    logic                m_valid_reg;
    logic                m_last_reg;

    // Decoded conditions
    logic                rd_req;
    logic                cap_stb;
    logic                pipe_flush;
    logic                is_last_idx;
    logic                is_last_word;
    logic                skip_word;
    logic [WORD_W-1:0]   w_inc;
    logic [IDX_W-1:0]    idx_inc;

    assign rd_req       = (state_reg == SEL);
    assign pipe_flush   = (state_reg == IDLE) || abort;
    assign is_last_idx  = (idx_reg == last_reg);
    assign is_last_word = (w_reg == WORD_LAST);
    assign skip_word    = SKIP_ZERO && (result_imp == '0) && !is_last_word;
    assign w_inc        = w_reg + WORD_W'(1);
    assign idx_inc      = idx_reg + IDX_W'(1);

    // Read-latency strobe: fires when result_imp belongs to the current sel
    prm_scan_rd_pipe #(
        .LAT   (READ_LAT)
    ) u_rd_pipe (
        .CLK   (CLK),
        .RST_n (RST_n),
        .flush (pipe_flush),
        .req   (rd_req),
        .stb   (cap_stb)
    );

    // Sweep FSM with all outputs registered; abort outranks every state
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            last_reg       <= '0;
            w_reg          <= '0;
            settle_cnt_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            slv_reg0_reg   <= '0;
            chk_clr_n_reg  <= 1'b1;
            sel1_reg       <= '0;
            sel2_reg       <= '0;
            m_data_reg     <= '0;
            m_idx_reg      <= '0;
            m_word_reg     <= '0;
            m_valid_reg    <= 1'b0;
            m_last_reg     <= 1'b0;
        end else begin
            // done and the clear strobe are single-cycle unless re-armed below
            done_reg      <= 1'b0;
            chk_clr_n_reg <= 1'b1;

            if (abort && (state_reg != IDLE)) begin
                // Truncate the stream; index and select lines keep their values
                state_reg   <= IDLE;
                busy_reg    <= 1'b0;
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            idx_reg       <= idx_first;
                            last_reg      <= idx_last;
                            slv_reg0_reg  <= idx_first;
                            chk_clr_n_reg <= 1'b0;
                            busy_reg      <= 1'b1;
                            state_reg     <= CLEAR;
                        end
                    end

                    CLEAR: begin
                        // chk_clr_n is low for this one cycle only
                        w_reg          <= '0;
                        settle_cnt_reg <= '0;
                        state_reg      <= SETTLE;
                    end

                    SETTLE: begin
                        if (settle_cnt_reg == SETTLE_END) begin
                            sel1_reg  <= bank_of(w_reg);
                            sel2_reg  <= word_sel_of(w_reg);
                            state_reg <= SEL;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + 8'd1;
                        end
                    end

                    // With READ_LAT = 0 the strobe fires in SEL itself, so both
                    // states share the capture path
                    SEL, WAIT_RD: begin
                        if (cap_stb) begin
                            if (skip_word) begin
                                w_reg     <= w_inc;
                                sel1_reg  <= bank_of(w_inc);
                                sel2_reg  <= word_sel_of(w_inc);
                                state_reg <= SEL;
                            end else begin
                                m_data_reg  <= result_imp;
                                m_idx_reg   <= idx_reg;
                                m_word_reg  <= w_reg;
                                m_last_reg  <= is_last_word && is_last_idx;
                                m_valid_reg <= 1'b1;
                                state_reg   <= EMIT;
                            end
                        end else begin
                            state_reg <= WAIT_RD;
                        end
                    end

                    EMIT: begin
                        if (m_ready) begin
                            m_valid_reg <= 1'b0;
                            m_last_reg  <= 1'b0;
                            if (is_last_word) begin
                                // Completion is flagged here so done lands the
                                // cycle right after the final handshake
                                if (is_last_idx) begin
                                    done_reg <= 1'b1;
                                    busy_reg <= 1'b0;
                                end
                                state_reg <= NEXT;
                            end else begin
                                w_reg     <= w_inc;
                                sel1_reg  <= bank_of(w_inc);
                                sel2_reg  <= word_sel_of(w_inc);
                                state_reg <= SEL;
                            end
                        end
                    end

                    NEXT: begin
                        if (is_last_idx) begin
                            state_reg <= IDLE;
                        end else begin
                            idx_reg       <= idx_inc;
                            slv_reg0_reg  <= idx_inc;
                            chk_clr_n_reg <= 1'b0;
                            state_reg     <= CLEAR;
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign slv_reg0  = slv_reg0_reg;
    assign chk_clr_n = chk_clr_n_reg;
    assign sel1      = sel1_reg;
    assign sel2      = sel2_reg;
    assign m_data    = m_data_reg;
    assign m_idx     = m_idx_reg;
    assign m_word    = m_word_reg;
    assign m_valid   = m_valid_reg;
    assign m_last    = m_last_reg;

endmodule

// File: tb/tb_prm_scan_ctrl.sv
// tb_prm_scan_ctrl: scoreboard bench for prm_scan_ctrl (default parameters).
// Expected beats are queued when a sweep is started and popped as the DUT
// hands them over. Honours PRM_SCAN_SKIP_ZERO_EN when built with it.
module tb_prm_scan_ctrl;

    typedef struct packed {
        logic [13:0] idx;
        logic [6:0]  w;
        logic [31:0] d;
        logic        last;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] idx_first = '0;
    logic [13:0] idx_last = '0;
    logic        busy, done, chk_clr_n, m_valid, m_last;
    logic        m_ready;
    logic [13:0] slv_reg0, m_idx;
    logic [2:0]  sel1;
    logic [7:0]  sel2;
    logic [31:0] result_imp = '0;
    logic [31:0] m_data;
    logic [6:0]  m_word;

    prm_scan_ctrl dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .start      (start),
        .abort      (abort),
        .idx_first  (idx_first),
        .idx_last   (idx_last),
        .busy       (busy),
        .done       (done),
        .slv_reg0   (slv_reg0),
        .chk_clr_n  (chk_clr_n),
        .sel1       (sel1),
        .sel2       (sel2),
        .result_imp (result_imp),
        .m_data     (m_data),
        .m_idx      (m_idx),
        .m_word     (m_word),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Result bank model: one cycle of read latency from sel1/sel2
    int model_mode = 0;
    function automatic logic [31:0] model_word(input int mode, input logic [13:0] idx,
                                               input logic [6:0] w);
        if (mode == 0) return {idx[6:0], w, 18'h0};
        return (w == 7'd3 || w == 7'd90) ? {16'hA5A5, 9'h0, w} : 32'h0;
    endfunction

    always @(posedge CLK) result_imp <= model_word(model_mode, slv_reg0, {sel1, sel2[3:0]});

    // Counters and scoreboard
    int    n_cmp = 0;
    int    n_err = 0;
    int    hs_cnt = 0, clr_cnt = 0, done_cnt = 0;
    int    first_valid_cyc = 0, last_hs_cyc = 0, done_cyc = 0, clr_first_cyc = 0;
    bit    seen_valid = 0;
    bit    stall_prev = 0;
    logic [53:0] held = '0;
    beat_t sb_q[$];
    logic [13:0] clr_q[$];

    // Ready pattern: 0 always ready, 1 random ~30 % ready, 2 ready for 40 beats
    int rdy_mode = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 99) < 30);
                default: m_ready = (hs_cnt < 40);
            endcase
        end
    end

    // Monitor: stall stability, scoreboard pops, clear/done bookkeeping
    always @(negedge CLK) begin
        if (RST_n) begin
            if (stall_prev && m_valid) begin
                n_cmp++;
                if ({m_data, m_idx, m_word, m_last} !== held) begin
                    n_err++;
                    $display("FAIL stall_hold: got %h, want %h", {m_data, m_idx, m_word, m_last}, held);
                end
            end
            stall_prev = m_valid && !m_ready;
            held = {m_data, m_idx, m_word, m_last};
            if (m_valid && !seen_valid) begin
                seen_valid = 1;
                first_valid_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                beat_t act;
                beat_t exp;
                act = {m_idx, m_word, m_data, m_last};
                hs_cnt++;
                last_hs_cyc = cyc;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got idx=%h w=%0d d=%h last=%b, want no beat",
                             act.idx, act.w, act.d, act.last);
                end else begin
                    exp = sb_q.pop_front();
                    if (act !== exp) begin
                        n_err++;
                        $display("FAIL beat: got idx=%h w=%0d d=%h last=%b, want idx=%h w=%0d d=%h last=%b",
                                 act.idx, act.w, act.d, act.last, exp.idx, exp.w, exp.d, exp.last);
                    end
                end
            end
            if (chk_clr_n === 1'b0) begin
                if (clr_cnt == 0) clr_first_cyc = cyc;
                clr_cnt++;
                clr_q.push_back(slv_reg0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 0;
        end
    end

    task automatic clear_stats();
        hs_cnt = 0;
        clr_cnt = 0;
        done_cnt = 0;
        seen_valid = 0;
        clr_q.delete();
        sb_q.delete();
    endtask

    task automatic push_sweep(input logic [13:0] first, input logic [13:0] last, input int mode);
        logic [13:0] idx;
        beat_t b;
        bit emit;
        idx = first;
        for (int n = 0; n < 16384; n++) begin
            for (int w = 0; w < 128; w++) begin
                b.idx  = idx;
                b.w    = 7'(w);
                b.d    = model_word(mode, idx, 7'(w));
                b.last = (w == 127) && (idx == last);
                emit   = 1;
`ifdef PRM_SCAN_SKIP_ZERO_EN
                if (b.d == 32'h0 && w != 127) emit = 0;
`endif
                if (emit) sb_q.push_back(b);
            end
            if (idx == last) break;
            idx = idx + 14'd1;
        end
    endtask

    task automatic pulse_start(input logic [13:0] first, input logic [13:0] last, output int s_cyc);
        @(posedge CLK);
        #1;
        idx_first = first;
        idx_last  = last;
        start     = 1'b1;
        s_cyc     = cyc;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, want done", name, budget);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [82:0] act, exp;
        RST_n = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        act = {busy, done, slv_reg0, chk_clr_n, sel1, sel2, m_data, m_idx, m_word, m_valid, m_last};
        exp = {1'b0, 1'b0, 14'h0, 1'b1, 3'h0, 8'h0, 32'h0, 14'h0, 7'h0, 1'b0, 1'b0};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL reset_values: got %h, want %h", act, exp);
        end
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_single();
        int s;
        logic [13:0] c0;
        clear_stats();
        model_mode = 0;
        rdy_mode = 0;
        push_sweep(14'h0155, 14'h0155, 0);
        pulse_start(14'h0155, 14'h0155, s);
        wait_done(2000, "single");
        c0 = (clr_q.size() > 0) ? clr_q[0] : 14'hx;
        n_cmp++; if (first_valid_cyc - s !== 8) begin n_err++;
            $display("FAIL single_first_valid: got %0d cycles, want 8", first_valid_cyc - s); end
        n_cmp++; if (clr_first_cyc - s !== 1) begin n_err++;
            $display("FAIL single_clr_latency: got %0d cycles, want 1", clr_first_cyc - s); end
        n_cmp++; if (clr_cnt !== 1) begin n_err++;
            $display("FAIL single_clr_count: got %0d, want 1", clr_cnt); end
        n_cmp++; if (c0 !== 14'h0155) begin n_err++;
            $display("FAIL single_clr_idx: got %h, want 0155", c0); end
        n_cmp++; if (hs_cnt !== 128 || sb_q.size() !== 0) begin n_err++;
            $display("FAIL single_beats: got %0d beats (%0d left), want 128 (0 left)", hs_cnt, sb_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL single_done_count: got %0d, want 1", done_cnt); end
        n_cmp++; if (done_cyc - last_hs_cyc !== 1) begin n_err++;
            $display("FAIL single_done_latency: got %0d, want 1", done_cyc - last_hs_cyc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL single_busy_after: got %b, want 0", busy); end
        $display("test_single: idx 0155, %0d beats", hs_cnt);
    endtask

    task automatic test_wrap();
        int s;
        logic [41:0] seq;
        clear_stats();
        push_sweep(14'd16383, 14'd1, 0);
        pulse_start(14'd16383, 14'd1, s);
        wait_done(5000, "wrap");
        seq = (clr_q.size() == 3) ? {clr_q[0], clr_q[1], clr_q[2]} : 42'hx;
        n_cmp++; if (clr_cnt !== 3) begin n_err++;
            $display("FAIL wrap_clr_count: got %0d, want 3", clr_cnt); end
        n_cmp++; if (seq !== {14'd16383, 14'd0, 14'd1}) begin n_err++;
            $display("FAIL wrap_idx_order: got %h, want %h", seq, {14'd16383, 14'd0, 14'd1}); end
        n_cmp++; if (hs_cnt !== 384 || sb_q.size() !== 0) begin n_err++;
            $display("FAIL wrap_beats: got %0d beats (%0d left), want 384 (0 left)", hs_cnt, sb_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL wrap_done_count: got %0d, want 1", done_cnt); end
        $display("test_wrap: 16383..1, %0d beats", hs_cnt);
    endtask

    task automatic test_stall();
        int s;
        clear_stats();
        rdy_mode = 1;
        push_sweep(14'd100, 14'd101, 0);
        pulse_start(14'd100, 14'd101, s);
        wait_done(10000, "stall");
        rdy_mode = 0;
        n_cmp++; if (hs_cnt !== 256 || sb_q.size() !== 0) begin n_err++;
            $display("FAIL stall_beats: got %0d beats (%0d left), want 256 (0 left)", hs_cnt, sb_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL stall_done_count: got %0d, want 1", done_cnt); end
        $display("test_stall: 100..101 random ready, %0d beats", hs_cnt);
    endtask

    task automatic test_abort();
        int s;
        bit found;
        clear_stats();
        rdy_mode = 2;
        push_sweep(14'h0022, 14'h0022, 0);
        pulse_start(14'h0022, 14'h0022, s);
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (m_valid === 1'b1 && m_word === 7'd40 && m_ready === 1'b0) begin
                found = 1;
                break;
            end
        end
        n_cmp++; if (!found) begin n_err++;
            $display("FAIL abort_reach_beat40: got timeout, want stalled beat 40"); end
        @(posedge CLK); #1; abort = 1'b1;
        @(posedge CLK); #1; abort = 1'b0;
        @(negedge CLK);
        n_cmp++; if ({m_valid, busy} !== 2'b00) begin n_err++;
            $display("FAIL abort_drop: got valid=%b busy=%b, want 0 0", m_valid, busy); end
        n_cmp++; if ({slv_reg0, sel1, sel2} !== {14'h0022, 3'd2, 8'd8}) begin n_err++;
            $display("FAIL abort_hold_sel: got %h/%h/%h, want 0022/2/08", slv_reg0, sel1, sel2); end
        sb_q.delete();
        rdy_mode = 0;
        repeat (10) @(negedge CLK);
        n_cmp++; if (done_cnt !== 0 || hs_cnt !== 40) begin n_err++;
            $display("FAIL abort_no_done: got done=%0d beats=%0d, want 0 and 40", done_cnt, hs_cnt); end
        // start together with abort while idle must not launch a sweep
        @(posedge CLK); #1; start = 1'b1; abort = 1'b1;
        @(posedge CLK); #1; start = 1'b0; abort = 1'b0;
        @(negedge CLK);
        n_cmp++; if ({busy, chk_clr_n} !== 2'b01) begin n_err++;
            $display("FAIL abort_beats_start: got busy=%b clr_n=%b, want 0 1", busy, chk_clr_n); end
        // a following sweep runs cleanly
        clear_stats();
        push_sweep(14'd7, 14'd7, 0);
        pulse_start(14'd7, 14'd7, s);
        wait_done(2000, "after_abort");
        n_cmp++; if (hs_cnt !== 128 || sb_q.size() !== 0 || done_cnt !== 1) begin n_err++;
            $display("FAIL after_abort_sweep: got beats=%0d left=%0d done=%0d, want 128 0 1",
                     hs_cnt, sb_q.size(), done_cnt); end
        $display("test_abort: aborted at beat 40, rerun %0d beats", hs_cnt);
    endtask

    task automatic test_sparse();
        int s;
        int want;
`ifdef PRM_SCAN_SKIP_ZERO_EN
        want = 3;
`else
        want = 128;
`endif
        clear_stats();
        model_mode = 1;
        push_sweep(14'h0030, 14'h0030, 1);
        pulse_start(14'h0030, 14'h0030, s);
        wait_done(2000, "sparse");
        n_cmp++; if (hs_cnt !== want || sb_q.size() !== 0) begin n_err++;
            $display("FAIL sparse_beats: got %0d beats (%0d left), want %0d (0 left)", hs_cnt, sb_q.size(), want); end
        n_cmp++; if (done_cnt !== 1) begin n_err++;
            $display("FAIL sparse_done_count: got %0d, want 1", done_cnt); end
        $display("test_sparse: %0d beats", hs_cnt);
    endtask

    task automatic test_reset_mid();
        int s;
        bit found;
        logic [82:0] act, exp;
        clear_stats();
        pulse_start(14'd9, 14'd9, s);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (chk_clr_n === 1'b0) begin
                found = 1;
                break;
            end
        end
        n_cmp++; if (!found) begin n_err++;
            $display("FAIL reset_mid_clear: got no clear, want clear"); end
        @(posedge CLK); #1;
        RST_n = 1'b0; start = 1'b1; idx_first = 14'd5; idx_last = 14'd5;
        @(posedge CLK); #1;
        @(negedge CLK);
        act = {busy, done, slv_reg0, chk_clr_n, sel1, sel2, m_data, m_idx, m_word, m_valid, m_last};
        exp = {1'b0, 1'b0, 14'h0, 1'b1, 3'h0, 8'h0, 32'h0, 14'h0, 7'h0, 1'b0, 1'b0};
        n_cmp++; if (act !== exp) begin n_err++;
            $display("FAIL reset_mid_values: got %h, want %h", act, exp); end
        @(posedge CLK); #1;
        RST_n = 1'b1; start = 1'b0;
        repeat (5) @(negedge CLK);
        n_cmp++; if (busy !== 1'b0 || clr_cnt !== 1) begin n_err++;
            $display("FAIL reset_mid_start_ignored: got busy=%b clears=%0d, want 0 1", busy, clr_cnt); end
        $display("test_reset_mid: reset during settle");
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_abort();
        test_sparse();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
